tl_ctrl: RTL and testbench

- Phase sequencer for the traffic-light timing datapath.
- Drives the datapath's one-hot `curr_state` and `dp_cnt_rst`, and consumes its sticky `done_state` flags.
- Walks the cycle G_LONG → NONE1 → G_SHORT1 → NONE2 → G_SHORT2 → Y → R, then repeats.
- Emits `red_done` to clear the datapath flags, decoded lamp outputs, a completed-cycle count, and a watchdog fault.

---
 rtl/tl_ctrl_pkg.sv | 99 +++++++++
 rtl/tl_wdog.sv | 45 ++++
 rtl/tl_ctrl.sv | 137 +++++++++++++
 tb/tb_tl_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_ctrl_pkg.sv
// Shared indices, state encoding and decode helpers for the traffic-light sequencer.
package tl_ctrl_pkg;

    localparam int unsigned STATE_W      = 4;
    localparam int unsigned STATE_DONE_W = 7;

    // curr_state one-hot bit positions
    localparam int unsigned S_G    = 0;
    localparam int unsigned S_Y    = 1;
    localparam int unsigned S_R    = 2;
    localparam int unsigned S_NONE = 3;

    // done_state flag positions
    localparam int unsigned DONE_G1    = 0;
    localparam int unsigned DONE_G2    = 1;
    localparam int unsigned DONE_G3    = 2;
    localparam int unsigned DONE_Y     = 3;
    localparam int unsigned DONE_R     = 4;
    localparam int unsigned DONE_NONE1 = 5;
    localparam int unsigned DONE_NONE2 = 6;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_G_LONG,
        ST_NONE1,
        ST_G_SHORT1,
        ST_NONE2,
        ST_G_SHORT2,
        ST_Y,
        ST_R,
        ST_FAULT
    } tl_state_e;

    // Timed phases are the ones that wait on a datapath done flag.
    function automatic logic is_timed(input tl_state_e s);
        logic t;
        case (s)
            ST_G_LONG, ST_NONE1, ST_G_SHORT1, ST_NONE2,
            ST_G_SHORT2, ST_Y, ST_R: t = 1'b1;
            default:                 t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic [2:0] exit_flag(input tl_state_e s);
        logic [2:0] idx;
        case (s)
            ST_G_LONG:   idx = 3'(DONE_G1);
            ST_NONE1:    idx = 3'(DONE_NONE1);
            ST_G_SHORT1: idx = 3'(DONE_G2);
            ST_NONE2:    idx = 3'(DONE_NONE2);
            ST_G_SHORT2: idx = 3'(DONE_G3);
            ST_Y:        idx = 3'(DONE_Y);
            default:     idx = 3'(DONE_R);
        endcase
        return idx;
    endfunction

    // Successor within the lamp cycle; R's successor depends on run and is resolved by the caller.
    function automatic tl_state_e next_phase(input tl_state_e s);
        tl_state_e n;
        case (s)
            ST_G_LONG:   n = ST_NONE1;
            ST_NONE1:    n = ST_G_SHORT1;
            ST_G_SHORT1: n = ST_NONE2;
            ST_NONE2:    n = ST_G_SHORT2;
            ST_G_SHORT2: n = ST_Y;
            ST_Y:        n = ST_R;
            default:     n = ST_G_LONG;
        endcase
        return n;
    endfunction

    function automatic logic [STATE_W-1:0] curr_of(input tl_state_e s);
        logic [STATE_W-1:0] v;
        v = '0;
        case (s)
            ST_G_LONG, ST_G_SHORT1, ST_G_SHORT2: v[S_G]    = 1'b1;
            ST_NONE1, ST_NONE2:                  v[S_NONE] = 1'b1;
            ST_Y, ST_FAULT:                      v[S_Y]    = 1'b1;
            ST_R:                                v[S_R]    = 1'b1;
            default:                             v         = '0;
        endcase
        return v;
    endfunction

    // {R,Y,G}; FAULT value is the first half of its blink.
    function automatic logic [2:0] light_of(input tl_state_e s);
        logic [2:0] l;
        case (s)
            ST_G_LONG, ST_G_SHORT1, ST_G_SHORT2: l = 3'b001;
            ST_NONE1, ST_NONE2:                  l = 3'b000;
            ST_Y, ST_FAULT:                      l = 3'b010;
            default:                             l = 3'b100;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tl_wdog.sv
// Per-phase watchdog: counts cycles since phase entry, flags a trip, and supplies the FAULT blink bit.
module tl_wdog
    import tl_ctrl_pkg::*;
#(
    parameter int unsigned WD_MAX = 2047
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    input  logic timed_i,
    output logic trip_o,
    output logic blink_o
);

    // At least 9 bits so bit 8 can serve as the 256-cycle blink.
    localparam int unsigned WD_W = ($clog2(WD_MAX + 1) > 9) ? $clog2(WD_MAX + 1) : 9;

    logic [WD_W-1:0] wd_q;
    logic [WD_W-1:0] wd_d;

    // Next count: clear on phase entry, otherwise advance while enabled.
    always_comb begin
        wd_d = wd_q;
        if (clr_i) begin
            wd_d = '0;
        end else if (en_i) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    // Trips on the edge at which the count would reach WD_MAX, i.e. WD_MAX cycles after entry.
    assign trip_o  = timed_i && (wd_q == WD_W'(WD_MAX - 1));
    assign blink_o = wd_d[8];

endmodule

// File: rtl/tl_ctrl.sv
// Traffic-light phase sequencer: walks the lamp cycle on datapath done flags, with watchdog fault.
module tl_ctrl
    import tl_ctrl_pkg::*;
#(
    parameter int unsigned WD_MAX = 2047,
    parameter int unsigned CYC_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    fault_clr,
    input  logic [STATE_DONE_W-1:0] done_state,
    output logic [STATE_W-1:0]      curr_state,
    output logic                    dp_cnt_rst,
    output logic                    red_done,
    output logic [2:0]              light,
    output logic [CYC_W-1:0]        cyc_cnt,
    output logic                    fault
);

    tl_state_e          state_q;
    tl_state_e          next_phase_d;
    logic [STATE_W-1:0] curr_q;
    logic               dp_rst_q;
    logic               red_done_q;
    logic [2:0]         light_q;
    logic [CYC_W-1:0]   cyc_q;
    logic               fault_q;

    logic timed;
    logic exit_hit;
    logic wd_trip;
    logic wd_blink;
    logic wd_clr;
    logic wd_en;

    assign timed    = is_timed(state_q);
    assign exit_hit = timed && done_state[exit_flag(state_q)];

    // Successor phase; leaving R either restarts the cycle or parks in IDLE.
    always_comb begin
        next_phase_d = next_phase(state_q);
        if (state_q == ST_R) begin
            next_phase_d = run ? ST_G_LONG : ST_IDLE;
        end
    end

    // Any state change restarts the watchdog; FAULT keeps it counting for the blink.
    assign wd_clr = exit_hit || wd_trip
                 || ((state_q == ST_IDLE)  && run)
                 || ((state_q == ST_FAULT) && fault_clr);
    assign wd_en  = timed || (state_q == ST_FAULT);

    tl_wdog #(
        .WD_MAX (WD_MAX)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (wd_clr),
        .en_i    (wd_en),
        .timed_i (timed),
        .trip_o  (wd_trip),
        .blink_o (wd_blink)
    );

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            curr_q     <= '0;
            dp_rst_q   <= 1'b1;
            red_done_q <= 1'b0;
            light_q    <= 3'b100;
            cyc_q      <= '0;
            fault_q    <= 1'b0;
        end else begin
            dp_rst_q   <= 1'b0;
            red_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    dp_rst_q <= 1'b1;
                    if (run) begin
                        state_q <= ST_G_LONG;
                        curr_q  <= curr_of(ST_G_LONG);
                        light_q <= light_of(ST_G_LONG);
                    end
                end
                ST_FAULT: begin
                    dp_rst_q <= 1'b1;
                    if (fault_clr) begin
                        state_q <= ST_IDLE;
                        curr_q  <= curr_of(ST_IDLE);
                        light_q <= light_of(ST_IDLE);
                        fault_q <= 1'b0;
                    end else begin
                        light_q <= wd_blink ? 3'b000 : 3'b010;
                    end
                end
                ST_G_LONG, ST_NONE1, ST_G_SHORT1, ST_NONE2,
                ST_G_SHORT2, ST_Y, ST_R: begin
                    // Exit flag is checked before the trip so a same-cycle flag still advances.
                    if (exit_hit) begin
                        state_q  <= next_phase_d;
                        curr_q   <= curr_of(next_phase_d);
                        light_q  <= light_of(next_phase_d);
                        dp_rst_q <= 1'b1;
                        if (state_q == ST_R) begin
                            red_done_q <= 1'b1;
                            cyc_q      <= cyc_q + 1'b1;
                        end
                    end else if (wd_trip) begin
                        state_q    <= ST_FAULT;
                        curr_q     <= curr_of(ST_FAULT);
                        light_q    <= light_of(ST_FAULT);
                        dp_rst_q   <= 1'b1;
                        red_done_q <= 1'b1;
                        fault_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    curr_q   <= '0;
                    light_q  <= 3'b100;
                    dp_rst_q <= 1'b1;
                end
            endcase
        end
    end

    assign curr_state = curr_q;
    assign dp_cnt_rst = dp_rst_q;
    assign red_done   = red_done_q;
    assign light      = light_q;
    assign cyc_cnt    = cyc_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_tl_ctrl.sv
// Self-checking bench for tl_ctrl with a behavioural datapath model driving the done flags.
module tb_tl_ctrl;

    localparam int unsigned WD_MAX = 2047;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       fault_clr;
    logic [6:0] done_state;
    logic [3:0] curr_state;
    logic       dp_cnt_rst;
    logic       red_done;
    logic [2:0] light;
    logic [7:0] cyc_cnt;
    logic       fault;

    logic       run2;
    logic [6:0] done_state2;
    logic [3:0] curr_state2;
    logic       dp_cnt_rst2;
    logic       red_done2;
    logic [2:0] light2;
    logic [1:0] cyc_cnt2;
    logic       fault2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tl_ctrl #(
        .WD_MAX (WD_MAX),
        .CYC_W  (8)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .fault_clr  (fault_clr),
        .done_state (done_state),
        .curr_state (curr_state),
        .dp_cnt_rst (dp_cnt_rst),
        .red_done   (red_done),
        .light      (light),
        .cyc_cnt    (cyc_cnt),
        .fault      (fault)
    );

    // Narrow counter instance: every flag permanently set, so each phase lasts one cycle.
    assign done_state2 = 7'h7F;

    tl_ctrl #(
        .WD_MAX (WD_MAX),
        .CYC_W  (2)
    ) u_dut2 (
        .clk        (clk),
        .reset      (reset),
        .run        (run2),
        .fault_clr  (1'b0),
        .done_state (done_state2),
        .curr_state (curr_state2),
        .dp_cnt_rst (dp_cnt_rst2),
        .red_done   (red_done2),
        .light      (light2),
        .cyc_cnt    (cyc_cnt2),
        .fault      (fault2)
    );

    // Expected per-phase curr_state / light, in cycle order G_LONG..R.
    logic [3:0]  exp_cs [7] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    logic [2:0]  exp_lt [7] = '{3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b010, 3'b100};
    int unsigned ph_n   [7];
    logic        y_hold;

    // Datapath model: cycle counter cleared by dp_cnt_rst; the phase's flag goes sticky at count N.
    logic [6:0]  flags;
    int unsigned dcnt;
    int unsigned tgt_pos;
    logic [2:0]  tgt_idx;
    logic        tgt_ok;

    always_comb begin
        tgt_ok  = 1'b1;
        tgt_idx = 3'd0;
        tgt_pos = 0;
        if (fault) begin
            tgt_ok = 1'b0;
        end else begin
            case (curr_state)
                4'b0001: begin
                    if (!flags[0])      begin tgt_idx = 3'd0; tgt_pos = 0; end
                    else if (!flags[1]) begin tgt_idx = 3'd1; tgt_pos = 2; end
                    else                begin tgt_idx = 3'd2; tgt_pos = 4; end
                end
                4'b1000: begin
                    if (!flags[5]) begin tgt_idx = 3'd5; tgt_pos = 1; end
                    else           begin tgt_idx = 3'd6; tgt_pos = 3; end
                end
                4'b0010: begin tgt_idx = 3'd3; tgt_pos = 5; tgt_ok = !y_hold; end
                4'b0100: begin tgt_idx = 3'd4; tgt_pos = 6; end
                default: tgt_ok = 1'b0;
            endcase
        end
    end

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            dcnt  <= 0;
            flags <= '0;
        end else begin
            dcnt <= dp_cnt_rst ? 0 : dcnt + 1;
            if (red_done) begin
                flags <= '0;
            end else if (!dp_cnt_rst && tgt_ok && (dcnt + 1 == ph_n[tgt_pos])) begin
                flags[tgt_idx] <= 1'b1;
            end
        end
    end

    assign done_state = flags;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_phases();
        for (int i = 0; i < 7; i++) begin
            ph_n[i] = (i == 0 || i == 6) ? $urandom_range(100, 1500) : $urandom_range(1, 300);
        end
    endtask

    // Called at the first-cycle negedge of phase `first`; returns at the first negedge after `last`.
    task automatic run_phases(input int first, input int last, input bit drop_run, input bit clr_glitch);
        int unsigned n, rd, drop_at, glitch_at;
        for (int p = first; p <= last; p++) begin
            chk($sformatf("curr_state p%0d", p), curr_state, exp_cs[p]);
            chk($sformatf("light p%0d", p), light, exp_lt[p]);
            chk($sformatf("dp_cnt_rst entry p%0d", p), dp_cnt_rst, 1);
            drop_at   = $urandom_range(1, ph_n[p]);
            glitch_at = $urandom_range(1, ph_n[p]);
            n  = 0;
            rd = 0;
            do begin
                @(negedge clk);
                n++;
                if (red_done) rd++;
                if (drop_run && p == 5 && n == drop_at) run = 1'b0;
                if (clr_glitch && p == 1) fault_clr = (n == glitch_at);
            end while (!dp_cnt_rst && n < 4000);
            fault_clr = 1'b0;
            chk($sformatf("phase length p%0d", p), n, ph_n[p] + 1);
            chk($sformatf("red_done count p%0d", p), rd, (p == 6) ? 1 : 0);
            chk($sformatf("fault p%0d", p), fault, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned k, n, w;
        reset     = 1'b0;
        run       = 1'b0;
        run2      = 1'b0;
        fault_clr = 1'b0;
        y_hold    = 1'b0;
        ph_n      = '{1025, 129, 129, 129, 129, 513, 1025};

        repeat (3) @(negedge clk);
        chk("rst curr_state", curr_state, 0);
        chk("rst dp_cnt_rst", dp_cnt_rst, 1);
        chk("rst red_done", red_done, 0);
        chk("rst light", light, 3'b100);
        chk("rst cyc_cnt", cyc_cnt, 0);
        chk("rst fault", fault, 0);
        chk("rst2 curr_state", curr_state2, 0);
        chk("rst2 cyc_cnt", cyc_cnt2, 0);

        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle curr_state", curr_state, 0);
        chk("idle light", light, 3'b100);
        chk("idle dp_cnt_rst", dp_cnt_rst, 1);

        // Narrow counter wraps 1,2,3,0.
        run2 = 1'b1;
        k = 0;
        n = 0;
        while (k < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (red_done2) begin
                k++;
                chk($sformatf("cyc_cnt2 #%0d", k), cyc_cnt2, k % 4);
                if (k == 4) run2 = 1'b0;
            end
        end
        chk("cyc_cnt2 pulses", k, 4);
        repeat (20) @(negedge clk);
        chk("cyc_cnt2 stopped", cyc_cnt2, 1);
        chk("curr_state2 stopped", curr_state2, 0);

        // Full cycle with nominal durations, fault_clr glitch outside FAULT.
        run = 1'b1;
        @(negedge clk);
        run_phases(0, 6, 1'b0, 1'b1);
        chk("cyc1 cyc_cnt", cyc_cnt, 1);
        chk("cyc1 restart curr", curr_state, 4'b0001);
        chk("cyc1 restart light", light, 3'b001);

        // Random durations, run dropped during Y.
        rand_phases();
        run_phases(0, 6, 1'b1, 1'b0);
        chk("stop cyc_cnt", cyc_cnt, 2);
        chk("stop curr", curr_state, 0);
        chk("stop light", light, 3'b100);
        chk("stop dp_cnt_rst", dp_cnt_rst, 1);
        repeat (50) @(negedge clk);
        chk("stop hold cyc_cnt", cyc_cnt, 2);
        chk("stop hold curr", curr_state, 0);
        chk("stop hold light", light, 3'b100);

        // Watchdog trip in Y.
        rand_phases();
        y_hold = 1'b1;
        run    = 1'b1;
        @(negedge clk);
        run_phases(0, 4, 1'b0, 1'b0);
        chk("wd Y entry", curr_state, 4'b0010);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fault && n < 3000);
        chk("fault latency", n, WD_MAX);
        chk("fault flag", fault, 1);
        chk("fault red_done", red_done, 1);
        chk("fault curr", curr_state, 4'b0010);
        chk("fault light", light, 3'b010);
        chk("fault dp_cnt_rst", dp_cnt_rst, 1);
        run = 1'b0;
        for (int m = 1; m <= 600; m++) begin
            @(negedge clk);
            chk($sformatf("blink m%0d", m), light, ((m / 256) % 2) ? 3'b000 : 3'b010);
            chk("fault red_done quiet", red_done, 0);
        end
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        chk("clr fault", fault, 0);
        chk("clr curr", curr_state, 0);
        chk("clr light", light, 3'b100);
        chk("clr cyc_cnt held", cyc_cnt, 2);
        y_hold = 1'b0;

        // Y flag arrives on the trip cycle: flag wins.
        rand_phases();
        ph_n[5] = WD_MAX - 1;
        run = 1'b1;
        @(negedge clk);
        run_phases(0, 6, 1'b0, 1'b0);
        chk("race fault", fault, 0);
        chk("race cyc_cnt", cyc_cnt, 3);
        chk("race restart curr", curr_state, 4'b0001);

        // Asynchronous reset in the middle of G_SHORT1.
        rand_phases();
        run_phases(0, 1, 1'b0, 1'b0);
        w = $urandom_range(0, ph_n[2]);
        repeat (w) @(negedge clk);
        chk("pre-reset curr", curr_state, 4'b0001);
        #2;
        reset = 1'b0;
        #1;
        chk("async curr", curr_state, 0);
        chk("async dp_cnt_rst", dp_cnt_rst, 1);
        chk("async red_done", red_done, 0);
        chk("async light", light, 3'b100);
        chk("async cyc_cnt", cyc_cnt, 0);
        chk("async fault", fault, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run   = 1'b1;
        @(negedge clk);
        chk("post-reset curr", curr_state, 4'b0001);
        chk("post-reset light", light, 3'b001);
        chk("post-reset dp_cnt_rst", dp_cnt_rst, 1);
        @(negedge clk);
        chk("post-reset dp pulse end", dp_cnt_rst, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
